rr_weighted_arb: RTL and testbench

RR_WEIGHTED_ARB -- requirements
Module: rr_weighted_arb

---
 rtl/rr_weighted_arb.sv | 184 ++++++++++++++++++
 tb/tb_rr_weighted_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_weighted_arb.sv
// ---------------------------------------------------------------------------
// rr_weighted_arb
//
// Weighted round-robin arbiter with N = 1<<N_log requesters. Each requester
// owns a programmable weight; a requester that wins a turn may keep the grant
// for weight+1 consecutive enabled cycles. i_lock can stretch a turn past that
// limit. Hand-over between requesters happens on the same edge the turn ends,
// so there is no idle bubble between back-to-back grants.
//
// Ports
//   Clk          clock, all state updates on the rising edge
//   Rst          synchronous active-high reset
//   i_en         advance enable; low freezes grant, pointer, counter and limit
//   i_req[N]     request vector
//   i_lock[N]    per-requester turn extension
//   i_wr_en      weight-table write strobe (honoured regardless of i_en)
//   i_wr_idx     weight-table write index
//   i_wr_weight  weight-table write data
//   o_gnt[N]     registered one-hot (or zero) grant
//   o_gnt_idx    binary index of o_gnt, 0 when no grant
//   o_busy       OR of o_gnt
// ---------------------------------------------------------------------------
module rr_weighted_arb #(
    parameter int N_log      = 3,
    parameter int W_BITS     = 4,
    parameter int DEF_WEIGHT = 0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                i_en,
    input  logic [(1<<N_log)-1:0] i_req,
    input  logic [(1<<N_log)-1:0] i_lock,
    input  logic                i_wr_en,
    input  logic [N_log-1:0]    i_wr_idx,
    input  logic [W_BITS-1:0]   i_wr_weight,
    output logic [(1<<N_log)-1:0] o_gnt,
    output logic [N_log-1:0]    o_gnt_idx,
    output logic                o_busy
);

    localparam int N = 1 << N_log;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [N-1:0]        gnt_reg, gnt_next;
    logic [N_log-1:0]    ptr_reg, ptr_next;
    logic [W_BITS-1:0]   cnt_reg, cnt_next;
    logic [W_BITS-1:0]   limit_reg, limit_next;
    logic [W_BITS-1:0]   weight_reg [N];

    logic [N_log-1:0]    holder_idx;
    logic [N_log-1:0]    scan_start;
    logic [N-1:0]        scan_mask;
    logic                scan_found;
    logic [N_log-1:0]    scan_sel;
    logic                turn_end;
    logic [N_log-1:0]    new_idx;
    logic [W_BITS-1:0]   new_weight;

    // -----------------------------------------------------------------------
    // Weight table. Each entry is its own register so the freshly granted
    // index can be read in the same cycle, including a same-edge write.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_weight
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    weight_reg[gi] <= W_BITS'(DEF_WEIGHT);
                end else if (i_wr_en && (i_wr_idx == N_log'(gi))) begin
                    weight_reg[gi] <= i_wr_weight;
                end
            end
        end
    endgenerate

    // Binary index of the current holder (grant is one-hot, so OR-ing the
    // indices of set bits gives the holder, or 0 when nothing is granted).
    always_comb begin
        holder_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_reg[i]) begin
                holder_idx = holder_idx | N_log'(i);
            end
        end
    end

    assign o_gnt     = gnt_reg;
    assign o_gnt_idx = holder_idx;
    assign o_busy    = |gnt_reg;

    // While holding, the scan starts just after the holder and skips it; in
    // IDLE it starts after the stored pointer over all requests.
    assign scan_start = (state_reg == HOLD) ? holder_idx : ptr_reg;
    assign scan_mask  = (state_reg == HOLD) ? (i_req & ~gnt_reg) : i_req;

    // Circular priority scan: scan_start+1, scan_start+2, ... wrapping mod N.
    always_comb begin
        logic [N_log-1:0] cand;
        scan_found = 1'b0;
        scan_sel   = '0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = scan_start + N_log'(i);
            if (!scan_found && scan_mask[cand]) begin
                scan_found = 1'b1;
                scan_sel   = cand;
            end
        end
    end

    assign turn_end = (state_reg == HOLD) &&
                      (!i_req[holder_idx] ||
                       ((cnt_reg == limit_reg) && !i_lock[holder_idx]));

    // Index that would start a new turn this edge; its limit comes from the
    // weight table, or from the write port when it targets the same entry.
    assign new_idx    = scan_found ? scan_sel : holder_idx;
    assign new_weight = (i_wr_en && (i_wr_idx == new_idx)) ? i_wr_weight
                                                           : weight_reg[new_idx];

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        limit_next = limit_reg;

        if (i_en) begin
            case (state_reg)
                IDLE: begin
                    if (scan_found) begin
                        state_next = HOLD;
                        gnt_next   = N'(1) << new_idx;
                        cnt_next   = '0;
                        limit_next = new_weight;
                    end
                end
                HOLD: begin
                    if (turn_end) begin
                        ptr_next = holder_idx;
                        if (scan_found || i_req[holder_idx]) begin
                            // Hand over, or re-grant the holder a fresh turn
                            // when nobody else is asking.
                            gnt_next   = N'(1) << new_idx;
                            cnt_next   = '0;
                            limit_next = new_weight;
                        end else begin
                            state_next = IDLE;
                            gnt_next   = '0;
                        end
                    end else if (cnt_reg != limit_reg) begin
                        // Counter stops at the limit while a lock holds the turn.
                        cnt_next = cnt_reg + W_BITS'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            ptr_reg   <= N_log'(N - 1);
            cnt_reg   <= '0;
            limit_reg <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            limit_reg <= limit_next;
        end
    end

endmodule

// File: tb/tb_rr_weighted_arb.sv
// ---------------------------------------------------------------------------
// tb_rr_weighted_arb
//
// Directed bench for rr_weighted_arb with N_log=2, W_BITS=4, DEF_WEIGHT=0.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge that just happened.
// ---------------------------------------------------------------------------
module tb_rr_weighted_arb;

    localparam int N_LOG = 2;
    localparam int N     = 1 << N_LOG;

    logic             Clk;
    logic             Rst;
    logic             i_en;
    logic [N-1:0]     i_req;
    logic [N-1:0]     i_lock;
    logic             i_wr_en;
    logic [N_LOG-1:0] i_wr_idx;
    logic [3:0]       i_wr_weight;
    logic [N-1:0]     o_gnt;
    logic [N_LOG-1:0] o_gnt_idx;
    logic             o_busy;

    int checks_cnt;
    int fail_cnt;

    rr_weighted_arb #(
        .N_log      (N_LOG),
        .W_BITS     (4),
        .DEF_WEIGHT (0)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_en        (i_en),
        .i_req       (i_req),
        .i_lock      (i_lock),
        .i_wr_en     (i_wr_en),
        .i_wr_idx    (i_wr_idx),
        .i_wr_weight (i_wr_weight),
        .o_gnt       (o_gnt),
        .o_gnt_idx   (o_gnt_idx),
        .o_busy      (o_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Checks grant, index and busy against one expected grant vector.
    task automatic expect_gnt(input string tag, input logic [N-1:0] exp_gnt);
        logic [31:0] exp_idx;
        exp_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) exp_idx = i;
        end
        $display("t=%0t %s req=%b lock=%b en=%b gnt=%b idx=%0d busy=%b",
                 $time, tag, i_req, i_lock, i_en, o_gnt, o_gnt_idx, o_busy);
        check({tag, ".gnt"},  32'(o_gnt),     32'(exp_gnt));
        check({tag, ".idx"},  32'(o_gnt_idx), exp_idx);
        check({tag, ".busy"}, 32'(o_busy),    32'(|exp_gnt));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_weight(input logic [N_LOG-1:0] idx, input logic [3:0] w);
        i_wr_en     = 1'b1;
        i_wr_idx    = idx;
        i_wr_weight = w;
        tick();
        i_wr_en     = 1'b0;
    endtask

    logic [N-1:0] seq_alt [4];
    logic [N-1:0] seq_w0  [8];

    initial begin
        checks_cnt  = 0;
        fail_cnt    = 0;
        Rst         = 1'b1;
        i_en        = 1'b1;
        i_req       = '0;
        i_lock      = '0;
        i_wr_en     = 1'b0;
        i_wr_idx    = '0;
        i_wr_weight = '0;

        seq_alt = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        seq_w0  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                    4'b0001, 4'b0001, 4'b0001, 4'b0010};

        // Reset state
        tick();
        tick();
        expect_gnt("reset", 4'b0000);
        Rst = 1'b0;

        // Equal weights alternate between 1 and 3 with no gap
        i_req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_gnt($sformatf("alt%0d", i), seq_alt[i]);
        end
        i_req = 4'b0000;
        tick();
        expect_gnt("alt_idle", 4'b0000);

        // Weight 3 on a lone requester: grant held continuously across re-grants
        write_weight(2'd2, 4'd3);
        i_req = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            tick();
            expect_gnt($sformatf("solo%0d", i), 4'b0100);
        end
        i_req = 4'b0000;
        tick();
        expect_gnt("solo_idle", 4'b0000);

        // weight[0]=2 vs weight[1]=0: 0 for three cycles, 1 for one
        write_weight(2'd0, 4'd2);
        i_req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_gnt($sformatf("w0_%0d", i), seq_w0[i]);
        end
        i_req = 4'b0000;
        tick();
        expect_gnt("w0_idle", 4'b0000);

        // Lock extends requester 1's turn; release hands over to 2
        i_req = 4'b0010;
        tick();
        expect_gnt("lock_start", 4'b0010);
        i_req  = 4'b1111;
        i_lock = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_gnt($sformatf("lock%0d", i), 4'b0010);
        end
        i_lock = 4'b0000;
        tick();
        expect_gnt("lock_release", 4'b0100);

        // Reset in the middle of requester 2's turn
        Rst = 1'b1;
        tick();
        expect_gnt("mid_rst0", 4'b0000);
        tick();
        expect_gnt("mid_rst1", 4'b0000);
        Rst = 1'b0;
        tick();
        expect_gnt("post_rst", 4'b0001);

        // Enable low freezes the grant; weight write still lands
        i_en        = 1'b0;
        i_wr_en     = 1'b1;
        i_wr_idx    = 2'd3;
        i_wr_weight = 4'd3;
        tick();
        i_wr_en = 1'b0;
        expect_gnt("frz0", 4'b0001);
        i_req = 4'b0000;
        tick();
        expect_gnt("frz1", 4'b0001);

        // Requester 3 (weight 3, written while frozen) drops mid-turn
        i_en  = 1'b1;
        i_req = 4'b1001;
        tick();
        expect_gnt("h3_start", 4'b1000);
        tick();
        expect_gnt("h3_hold", 4'b1000);
        i_req = 4'b0001;
        tick();
        expect_gnt("h3_drop", 4'b0001);
        i_req = 4'b0000;
        tick();
        expect_gnt("all_drop", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
